// File: rtl/digit_detect_pkg.sv
// Shared network definitions: layer-2 output geometry, sigmoid register widths
// and the argmax detect state encoding.
package digit_detect_pkg;

    localparam int NUM_OUTPUT_NEURONS = 10;
    localparam int LAYER2_SIG_BASE    = 8;
    localparam int SIG_DATA_W         = 4;
    localparam int SIG_ADDR_W         = 5;
    localparam int IDX_W              = 4;

    // Kept apart from the controller's enum so the two FSMs can evolve independently.
    typedef enum logic [1:0] {
        DET_IDLE = 2'd0,
        DET_SCAN = 2'd1,
        DET_HOLD = 2'd2
    } detect_state_t;

endpackage

// File: rtl/digit_detect_argmax_step.sv
// One compare step of the running argmax: folds a new activation into the best-so-far.
module argmax_step
    import digit_detect_pkg::*;
#(
    parameter int DATA_W = SIG_DATA_W
) (
    input  logic [DATA_W-1:0] cur_val,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic              cur_tie,
    input  logic              first,
    input  logic [DATA_W-1:0] in_val,
    input  logic [IDX_W-1:0]  in_idx,
    output logic [DATA_W-1:0] nxt_val,
    output logic [IDX_W-1:0]  nxt_idx,
    output logic              nxt_tie
);

    always_comb begin
        nxt_val = cur_val;
        nxt_idx = cur_idx;
        nxt_tie = cur_tie;
        if (first || (in_val > cur_val)) begin
            nxt_val = in_val;
            nxt_idx = in_idx;
            nxt_tie = 1'b0;
        end else if (in_val == cur_val) begin
            // Equal value: the lower index already held wins, only flag the tie.
            nxt_tie = 1'b1;
        end
    end

endmodule

// File: rtl/digit_detect.sv
// Output-layer argmax: scans the layer-2 sigmoid registers after network_done and
// holds the winning digit, its confidence and a tie flag until the SPI block acks.
module digit_detect
    import digit_detect_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_OUTPUT_NEURONS,
    parameter int BASE_ADDR   = LAYER2_SIG_BASE,
    parameter int ADDR_W      = SIG_ADDR_W,
    parameter int DATA_W      = SIG_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              network_done,
    input  logic [DATA_W-1:0] sig_rdata,
    output logic [ADDR_W-1:0] sig_raddr,
    output logic              sig_rd_own,
    input  logic              result_ack,
    output logic [3:0]        digit,
    output logic [DATA_W-1:0] confidence,
    output logic              tie,
    output logic              digit_valid,
    output logic              busy
);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    detect_state_t     state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] best_val;
    logic [IDX_W-1:0]  best_idx;
    logic              best_tie;
    logic [DATA_W-1:0] nxt_val;
    logic [IDX_W-1:0]  nxt_idx;
    logic              nxt_tie;

    assign idx_next = idx + 4'd1;

    argmax_step #(.DATA_W(DATA_W)) u_step (
        .cur_val (best_val),
        .cur_idx (best_idx),
        .cur_tie (best_tie),
        .first   (idx == 4'd0),
        .in_val  (sig_rdata),
        .in_idx  (idx),
        .nxt_val (nxt_val),
        .nxt_idx (nxt_idx),
        .nxt_tie (nxt_tie)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= DET_IDLE;
            idx         <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            best_tie    <= 1'b0;
            sig_raddr   <= '0;
            sig_rd_own  <= 1'b0;
            busy        <= 1'b0;
            digit       <= '0;
            confidence  <= '0;
            tie         <= 1'b0;
            digit_valid <= 1'b0;
        end else begin
            case (state)
                DET_IDLE: begin
                    if (network_done) begin
                        state      <= DET_SCAN;
                        idx        <= '0;
                        sig_raddr  <= BASE;
                        sig_rd_own <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                DET_SCAN: begin
                    best_val <= nxt_val;
                    best_idx <= nxt_idx;
                    best_tie <= nxt_tie;
                    if (idx == LAST_IDX) begin
                        state       <= DET_HOLD;
                        idx         <= '0;
                        sig_raddr   <= '0;
                        sig_rd_own  <= 1'b0;
                        busy        <= 1'b0;
                        digit       <= nxt_idx;
                        confidence  <= nxt_val;
                        tie         <= nxt_tie;
                        digit_valid <= 1'b1;
                    end else begin
                        idx       <= idx_next;
                        sig_raddr <= BASE + ADDR_W'(idx_next);
                    end
                end
                DET_HOLD: begin
                    // A new network result takes priority over acknowledging the old one.
                    if (network_done) begin
                        state       <= DET_SCAN;
                        idx         <= '0;
                        sig_raddr   <= BASE;
                        sig_rd_own  <= 1'b1;
                        busy        <= 1'b1;
                        digit_valid <= 1'b0;
                    end else if (result_ack) begin
                        state       <= DET_IDLE;
                        digit_valid <= 1'b0;
                    end
                end
                default: state <= DET_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_detect.sv
// Scoreboard bench for digit_detect: default 10-class instance plus a 2-class instance.
module tb_digit_detect;

    typedef struct {
        int digit;
        int conf;
        int tie;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       network_done = 1'b0;
    logic       result_ack = 1'b0;
    logic [3:0] sig_rdata;
    logic [4:0] sig_raddr;
    logic       sig_rd_own;
    logic [3:0] digit;
    logic [3:0] confidence;
    logic       tie;
    logic       digit_valid;
    logic       busy;

    logic       network_done2 = 1'b0;
    logic       result_ack2 = 1'b0;
    logic [3:0] sig_rdata2;
    logic [4:0] sig_raddr2;
    logic       sig_rd_own2;
    logic [3:0] digit2;
    logic [3:0] confidence2;
    logic       tie2;
    logic       digit_valid2;
    logic       busy2;

    logic [3:0] regs  [32];
    logic [3:0] regs2 [32];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t q2[$];

    logic       dv_prev = 1'b0;
    logic       dv2_prev = 1'b0;
    logic [8:0] fields_prev = '0;

    assign sig_rdata  = regs[sig_raddr];
    assign sig_rdata2 = regs2[sig_raddr2];

    digit_detect u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .network_done (network_done),
        .sig_rdata    (sig_rdata),
        .sig_raddr    (sig_raddr),
        .sig_rd_own   (sig_rd_own),
        .result_ack   (result_ack),
        .digit        (digit),
        .confidence   (confidence),
        .tie          (tie),
        .digit_valid  (digit_valid),
        .busy         (busy)
    );

    digit_detect #(.NUM_CLASSES(2), .BASE_ADDR(0), .ADDR_W(5), .DATA_W(4)) u_dut2 (
        .clk          (clk),
        .n_rst        (n_rst),
        .network_done (network_done2),
        .sig_rdata    (sig_rdata2),
        .sig_raddr    (sig_raddr2),
        .sig_rd_own   (sig_rd_own2),
        .result_ack   (result_ack2),
        .digit        (digit2),
        .confidence   (confidence2),
        .tie          (tie2),
        .digit_valid  (digit_valid2),
        .busy         (busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising digit_valid is matched against the oldest expected result.
    always @(negedge clk) begin
        if (digit_valid && !dv_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("digit", digit, q[0].digit);
                chk("confidence", confidence, q[0].conf);
                chk("tie", tie, q[0].tie);
                chk("latency_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
        end
        if (digit_valid && dv_prev)
            chk("hold_stable", {digit, confidence, tie}, fields_prev);
        dv_prev     <= digit_valid;
        fields_prev <= {digit, confidence, tie};
    end

    always @(negedge clk) begin
        if (digit_valid2 && !dv2_prev) begin
            if (q2.size() == 0) begin
                chk("unexpected_result2", 1, 0);
            end else begin
                chk("digit2", digit2, q2[0].digit);
                chk("confidence2", confidence2, q2[0].conf);
                chk("tie2", tie2, q2[0].tie);
                chk("latency_cycle2", cyc, q2[0].cyc);
                void'(q2.pop_front());
            end
        end
        dv2_prev <= digit_valid2;
    end

    // Nibble i (from the MSB) goes to register 8+i.
    task automatic load(input logic [39:0] v);
        for (int i = 0; i < 10; i++) regs[8+i] = v[39-4*i -: 4];
    endtask

    task automatic pulse(input int d, input int c, input int t);
        network_done = 1'b1;
        q.push_back('{d, c, t, cyc + 11});
        @(negedge clk);
        network_done = 1'b0;
    endtask

    task automatic pulse2(input int d, input int c, input int t);
        network_done2 = 1'b1;
        q2.push_back('{d, c, t, cyc + 3});
        @(negedge clk);
        network_done2 = 1'b0;
    endtask

    task automatic ack_hold();
        chk("valid_before_ack", digit_valid, 1);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk("valid_after_ack", digit_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i]  = 4'(i);
            regs2[i] = 4'd0;
        end

        #1;
        chk("rst_busy", busy, 0);
        chk("rst_own", sig_rd_own, 0);
        chk("rst_raddr", sig_raddr, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_fields", {digit, confidence, tie}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Basic scan with address stepping
        load(40'h1329045678);
        pulse(3, 9, 0);
        for (int k = 0; k < 10; k++) begin
            chk("scan_raddr", sig_raddr, 8 + k);
            chk("scan_own", sig_rd_own, 1);
            chk("scan_busy", busy, 1);
            @(negedge clk);
        end
        chk("hold_raddr", sig_raddr, 0);
        chk("hold_own", sig_rd_own, 0);
        chk("hold_busy", busy, 0);
        repeat (3) @(negedge clk);
        ack_hold();
        chk("retain_digit", digit, 3);
        chk("retain_conf", confidence, 9);

        // Ack outside HOLD does nothing
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_valid", digit_valid, 0);

        // Ties: highest value shared, then all zeros
        load(40'h52FF00000F);
        pulse(2, 15, 1);
        repeat (10) @(negedge clk);
        ack_hold();
        load(40'h0000000000);
        pulse(0, 0, 1);
        repeat (10) @(negedge clk);
        ack_hold();

        // network_done mid-scan is ignored
        load(40'h1329045678);
        pulse(3, 9, 0);
        repeat (3) @(negedge clk);
        network_done = 1'b1;
        @(negedge clk);
        network_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("orig_timing_valid", digit_valid, 1);

        // Restart from HOLD without ack
        load(40'h1111111C11);
        pulse(7, 12, 0);
        chk("restart_valid_drop", digit_valid, 0);
        chk("restart_busy", busy, 1);
        repeat (10) @(negedge clk);

        // Ack and done together in HOLD: done wins
        load(40'h52FF00000F);
        result_ack = 1'b1;
        pulse(2, 15, 1);
        result_ack = 1'b0;
        chk("ackdone_busy", busy, 1);
        chk("ackdone_own", sig_rd_own, 1);
        chk("ackdone_valid", digit_valid, 0);
        repeat (10) @(negedge clk);
        ack_hold();

        // Asynchronous reset in the middle of a scan
        load(40'h1329045678);
        pulse(3, 9, 0);
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        void'(q.pop_back());
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_own", sig_rd_own, 0);
        chk("midrst_raddr", sig_raddr, 0);
        chk("midrst_valid", digit_valid, 0);
        chk("midrst_fields", {digit, confidence, tie}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        chk("postrst_ack_busy", busy, 0);
        repeat (12) @(negedge clk);
        chk("postrst_no_valid", digit_valid, 0);
        pulse(3, 9, 0);
        repeat (10) @(negedge clk);
        ack_hold();

        // Two-class instance at base address 0
        regs2[0] = 4'd6;
        regs2[1] = 4'd4;
        pulse2(0, 6, 0);
        chk("small_raddr0", sig_raddr2, 0);
        chk("small_own", sig_rd_own2, 1);
        @(negedge clk);
        chk("small_raddr1", sig_raddr2, 1);
        @(negedge clk);
        chk("small_valid", digit_valid2, 1);
        result_ack2 = 1'b1;
        @(negedge clk);
        result_ack2 = 1'b0;
        chk("small_ack", digit_valid2, 0);
        regs2[0] = 4'd4;
        regs2[1] = 4'd6;
        pulse2(1, 6, 0);
        repeat (2) @(negedge clk);
        chk("small_valid_b", digit_valid2, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size() + q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
